// File: rtl/keypad_pkg.sv
// Shared 4x4 keypad definitions: FSM states and the key-to-(column,row) map.
// The scanner imports the same package so both ends agree on the mapping.
package keypad_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BOUNCE_IN,
    S_HOLD,
    S_BOUNCE_OUT,
    S_GAP
  } kp_state_e;

  localparam int KEY_COL_LSB = 0;
  localparam int KEY_COL_MSB = 1;
  localparam int KEY_ROW_LSB = 2;
  localparam int KEY_ROW_MSB = 3;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/keypad_emulator.sv
// Keypad side of a column-scan/row-sense link: presses one key per request
// with optional contact bounce, then releases it and waits an inter-key gap.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int PRESS_CYCLES  = 16,
  parameter int BOUNCE_CYCLES = 8,
  parameter int BOUNCE_PERIOD = 2,
  parameter int GAP_CYCLES    = 8,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       bounce_en,
  output logic       key_ready,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] BNC_LAST  = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PER_LAST  = CNT_W'(BOUNCE_PERIOD - 1);
  localparam bit               BNC_ON    = (BOUNCE_CYCLES > 0);

  kp_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ph_q, ph_d;
  logic             contact_q, contact_d;
  logic [1:0]       c_q, c_d;
  logic [1:0]       r_q, r_d;
  logic             ben_q, ben_d;
  logic             done_q, done_d;
  logic             ph_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ph_q      <= '0;
      contact_q <= 1'b0;
      c_q       <= '0;
      r_q       <= '0;
      ben_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ph_q      <= ph_d;
      contact_q <= contact_d;
      c_q       <= c_d;
      r_q       <= r_d;
      ben_q     <= ben_d;
      done_q    <= done_d;
    end
  end

  // ph_q tracks position inside the current bounce period
  assign ph_wrap = (ph_q == PER_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    ph_d      = ph_wrap ? '0 : ph_q + 1'b1;
    contact_d = contact_q;
    c_d       = c_q;
    r_d       = r_q;
    ben_d     = ben_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        ph_d  = '0;
        if (key_valid) begin
          c_d       = key_code[KEY_COL_MSB:KEY_COL_LSB];
          r_d       = key_code[KEY_ROW_MSB:KEY_ROW_LSB];
          ben_d     = bounce_en;
          contact_d = 1'b1;
          state_d   = (bounce_en && BNC_ON) ? S_BOUNCE_IN : S_HOLD;
        end
      end
      S_BOUNCE_IN: begin
        if (cnt_q == BNC_LAST) begin
          state_d   = S_HOLD;
          cnt_d     = '0;
          ph_d      = '0;
          contact_d = 1'b1;
        end else if (ph_wrap) begin
          contact_d = ~contact_q;
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d   = (ben_q && BNC_ON) ? S_BOUNCE_OUT : S_GAP;
          cnt_d     = '0;
          ph_d      = '0;
          contact_d = 1'b0;
        end
      end
      S_BOUNCE_OUT: begin
        if (cnt_q == BNC_LAST) begin
          state_d   = S_GAP;
          cnt_d     = '0;
          ph_d      = '0;
          contact_d = 1'b0;
        end else if (ph_wrap) begin
          contact_d = ~contact_q;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          ph_d    = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        ph_d      = '0;
        contact_d = 1'b0;
      end
    endcase
  end

  assign row = (contact_q && (col == onehot4(c_q))) ? onehot4(r_q) : 4'b0000;
  assign key_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench: stimulus queues per-cycle expectations, a monitor checks.
module tb_keypad_emulator;

  localparam int HOLD_N = 16;
  localparam int BNC_N  = 8;
  localparam int PER_N  = 2;
  localparam int GAP_N  = 8;

  logic       clk;
  logic       rst;
  logic [3:0] col;
  logic [3:0] row;
  logic       key_valid;
  logic [3:0] key_code;
  logic       bounce_en;
  logic       key_ready;
  logic       busy;
  logic       done;

  typedef struct packed {
    logic [63:0] name;
    logic [3:0]  row;
    logic        busy;
    logic        rdy;
    logic        done;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  keypad_emulator dut (
    .clk(clk), .rst(rst), .col(col), .row(row),
    .key_valid(key_valid), .key_code(key_code), .bounce_en(bounce_en),
    .key_ready(key_ready), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] mrow(input logic [3:0] c,
                                      input logic [3:0] k,
                                      input logic ct);
    logic [3:0] cm;
    logic [3:0] rm;
    cm = 4'b0001 << k[1:0];
    rm = 4'b0001 << k[3:2];
    return (ct && c == cm) ? rm : 4'b0000;
  endfunction

  function automatic logic [3:0] colsel(input int mode,
                                        input logic [3:0] k,
                                        input int i);
    logic [3:0] m;
    m = 4'b0001 << k[1:0];
    if (mode == 1) return 4'b0001 << (i % 4);
    if (mode == 2) begin
      if (i % 3 == 1) return 4'b0000;
      if (i % 3 == 2) return 4'b1100;
    end
    return m;
  endfunction

  task automatic push(input logic [63:0] nm, input logic [3:0] er,
                      input logic eb, input logic ed);
    exp_t e;
    e.name = nm;
    e.row  = er;
    e.busy = eb;
    e.rdy  = ~eb;
    e.done = ed;
    q.push_back(e);
  endtask

  task automatic cyc(input logic [3:0] c, input logic kv,
                     input logic [3:0] code, input logic ben,
                     input logic [3:0] er, input logic eb,
                     input logic ed, input logic [63:0] nm);
    @(posedge clk);
    #1;
    col       = c;
    key_valid = kv;
    key_code  = code;
    bounce_en = ben;
    push(nm, er, eb, ed);
  endtask

  task automatic run_key(input logic [3:0] k, input logic ben,
                         input int mode, input logic nkv,
                         input logic [3:0] ncode, input logic skip_acc,
                         input logic [63:0] nm);
    int i;
    logic [3:0] c;
    logic ct;
    i = 0;
    if (!skip_acc)
      cyc(colsel(mode, k, 0), 1'b1, k, ben, 4'b0000, 1'b0, 1'b0, nm);
    if (ben) begin
      for (int n = 0; n < BNC_N; n++) begin
        ct = ((n / PER_N) % 2 == 0);
        c  = colsel(mode, k, i++);
        cyc(c, nkv, ncode, 1'b0, mrow(c, k, ct), 1'b1, 1'b0, nm);
      end
    end
    for (int n = 0; n < HOLD_N; n++) begin
      c = colsel(mode, k, i++);
      cyc(c, nkv, ncode, 1'b0, mrow(c, k, 1'b1), 1'b1, 1'b0, nm);
    end
    if (ben) begin
      for (int n = 0; n < BNC_N; n++) begin
        ct = ((n / PER_N) % 2 == 1);
        c  = colsel(mode, k, i++);
        cyc(c, nkv, ncode, 1'b0, mrow(c, k, ct), 1'b1, 1'b0, nm);
      end
    end
    for (int n = 0; n < GAP_N; n++) begin
      c = colsel(mode, k, i++);
      cyc(c, nkv, ncode, 1'b0, 4'b0000, 1'b1, 1'b0, nm);
    end
    c = colsel(mode, k, i);
    cyc(c, nkv, ncode, 1'b0, 4'b0000, 1'b0, 1'b1, nm);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (row !== e.row || busy !== e.busy ||
            key_ready !== e.rdy || done !== e.done) begin
          errors++;
          $display("FAIL %s got row=%b busy=%b rdy=%b done=%b want row=%b busy=%b rdy=%b done=%b",
                   e.name, row, busy, key_ready, done,
                   e.row, e.busy, e.rdy, e.done);
        end
      end
    end
  end

  initial begin : stim
    rst       = 1'b1;
    col       = 4'b0001;
    key_valid = 1'b0;
    key_code  = 4'h0;
    bounce_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    push("reset", 4'b0000, 1'b0, 1'b0);

    cyc(4'b0001, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b0, 1'b0, "idle");
    run_key(4'h5, 1'b0, 1, 1'b0, 4'h0, 1'b0, "k5_rot");
    cyc(4'b0010, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b0, 1'b0, "k5_post");

    run_key(4'hF, 1'b0, 2, 1'b0, 4'h0, 1'b0, "kF_mix");
    cyc(4'b1000, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b0, 1'b0, "kF_post");

    run_key(4'h0, 1'b1, 0, 1'b0, 4'h0, 1'b0, "k0_bnc");
    cyc(4'b0001, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b0, 1'b0, "k0_post");

    run_key(4'h9, 1'b0, 0, 1'b1, 4'h3, 1'b0, "k9_b2b");
    run_key(4'h3, 1'b0, 0, 1'b0, 4'h0, 1'b1, "k3_b2b");

    cyc(4'b0100, 1'b1, 4'hA, 1'b0, 4'b0000, 1'b0, 1'b0, "kA_acc");
    for (int n = 0; n < 4; n++)
      cyc(4'b0100, 1'b0, 4'h0, 1'b0, 4'b0100, 1'b1, 1'b0, "kA_hold");
    @(posedge clk);
    #1;
    rst = 1'b1;
    push("kA_h5", 4'b0100, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push("kA_rst", 4'b0000, 1'b0, 1'b0);
    for (int n = 0; n < 30; n++)
      cyc(4'b0100, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b0, 1'b0, "post_rst");

    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
- Synthesizable responder for the 4x4 matrix-keypad interface: the keypad side of the column-scan/row-sense link.
- Accepts a key code over a valid/ready handshake and drives the row lines as a physical keypad would while the scanner strobes the columns.
- Models press, contact bounce, hold, release and an inter-key gap.
- Used for on-FPGA loopback self-test of the keypad scanner and for scanner verification without physical keys.

Parameters:
- PRESS_CYCLES, 16: clean-hold duration in clk cycles, >=1.
- BOUNCE_CYCLES, 8: length of each bounce window (press and release) in cycles; 0 disables bounce entirely.
- BOUNCE_PERIOD, 2: cycles between contact toggles inside a bounce window, >=1.
- GAP_CYCLES, 8: released time after a key before done, >=1.
- CNT_W, 16: phase counter width; every cycle parameter must be < 2^CNT_W.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- col  in  4  column strobe from scanner; one-hot, col[c] drives column c
- row  out  4  row sense to scanner; row[r] high when the key at (c,r) is closed and column c is strobed
- key_valid  in  1  request to press key_code
- key_code  in  4  hex key 0-F
- bounce_en  in  1  sampled with key_code; enables bounce windows for this key
- key_ready  out  1  high in IDLE
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when the key sequence completes

Behaviour:
- Key map: column index c = key[1:0], row index r = key[3:2]. Key 0 = (col 0001, row 0001); key 4 = (col 0001, row 0010); key 1 = (col 0010, row 0001); key F = (col 1000, row 1000).
- row = onehot(r_lat) when contact is closed AND col == onehot(c_lat); otherwise 4'b0000.
  - row is combinational from col and registered state: zero-cycle latency from col.
  - A col that is not exactly the matching one-hot (0000, multi-hot, other column) gives row = 0000.
- Reset values: state IDLE, contact open, row 0000, key_ready 1, busy 0, done 0, latched key 0, counter 0. Reset asserted mid-sequence aborts at the next edge; no done pulse is produced.
- Handshake:
  - Accept on the edge where key_valid && key_ready. key_code and bounce_en are latched on that edge.
  - key_valid while busy is ignored and is not queued.
- FSM states: IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP.
  - IDLE -> BOUNCE_IN on accept if bounce_en_lat && BOUNCE_CYCLES>0; otherwise IDLE -> HOLD.
  - BOUNCE_IN: lasts exactly BOUNCE_CYCLES cycles. Contact is closed in the first cycle and inverts every BOUNCE_PERIOD cycles. Then -> HOLD.
  - HOLD: contact closed for exactly PRESS_CYCLES cycles. Then -> BOUNCE_OUT if bounce is enabled for this key, else -> GAP.
  - BOUNCE_OUT: lasts BOUNCE_CYCLES cycles. Contact is open in the first cycle and inverts every BOUNCE_PERIOD cycles. Then -> GAP.
  - GAP: contact open for GAP_CYCLES cycles. Then -> IDLE.
- Counter: loads 0 on every state entry and increments each cycle. The state exits when counter == duration-1. A toggle occurs when the in-window count reaches a multiple of BOUNCE_PERIOD.
- done: registered; high exactly in the first IDLE cycle after GAP. key_ready is also 1 in that cycle, so a new key may be accepted on the same edge (back-to-back).

Decomposition:
- keypad_pkg: state enum; onehot4 function (2-bit index -> 4-bit one-hot); key-to-(col,row) field constants, shared with the keypad scanner so both ends use one mapping.
- No sub-module; counter and FSM live in one module.

Test Plan:
- Reset, then key 5, bounce_en=0, col rotating 0001->0010->0100->1000 each cycle -> row=0010 only on col=0010 cycles, during exactly 16 HOLD cycles; busy low and done=1 on cycle 1+16+8 after accept.
- Key F, bounce_en=0, col held 1000 -> row=1000 for 16 cycles; col=0000 or 1100 -> row=0000 in all states.
- Key 0, bounce_en=1, col held 0001 -> row toggles 0001/0000 every 2 cycles for 8 cycles (starting 0001), then 16 cycles of 0001, then 8 toggling cycles (starting 0000), then 0000 for 8 cycles, then done.
- key_valid held high with code 9, then code 3 -> 9 is accepted; 3 is ignored while busy and accepted on the done cycle with no idle bubble.
- rst asserted on HOLD cycle 5 of key A -> next cycle row=0000, state IDLE, busy 0, key_ready 1, done never pulses.
